// File: rtl/detector_emulator.sv
// detector_emulator: regenerates detector-style raster signalling (pixel strobe,
// line sync, frame sync, pixel data) from a 14-bit Avalon-ST video stream.
// An Avalon-MM slave exposes go, sticky status, fill value and a frame counter.
// Optional feature macro: DETECTOR_EMU_PATTERN_EN adds register 4 (bit0 selects
// a diagonal (h_cnt + v_cnt) test pattern in place of streamed video).
module detector_emulator #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 32,
  parameter int V_ACTIVE = 512,
  parameter int V_BLANK  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  av_address,
  input  logic        av_read,
  output logic [31:0] av_readdata,
  input  logic        av_write,
  input  logic [31:0] av_writedata,
  input  logic        din_startofpacket,
  input  logic        din_endofpacket,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [13:0] din_data,
  output logic        dd_psync,
  output logic        dd_hsync,
  output logic        dd_vsync,
  output logic [13:0] dd_video
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_PIX_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_PIX_LAST = VW'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [HW-1:0]  r_h_cnt;
  logic [VW-1:0]  r_v_cnt;
  logic           r_go;
  logic [2:0]     r_status;
  logic [13:0]    r_fill;
  logic [31:0]    r_frame_cnt;
  logic           r_eop_seen;
  logic [31:0]    r_readdata;
  logic           r_psync, r_hsync, r_vsync;
  logic [13:0]    r_video;

  logic           w_pixel, w_line_act, w_frame_start, w_last_pix;
  logic           w_run, w_ready, w_sop_take, w_stream_pix, w_frame_begin;
  logic           w_in_stream, w_take, w_pattern;
  logic [13:0]    w_pix_val;
  logic [2:0]     w_set, w_clr;
  logic [31:0]    w_rd_mux;
  logic           w_unused;

`ifdef DETECTOR_EMU_PATTERN_EN
  logic           r_pattern;
  logic [13:0]    w_pat_val;
  assign w_pattern = r_pattern;
  assign w_pat_val = 14'(r_h_cnt) + 14'(r_v_cnt);
`else
  assign w_pattern = 1'b0;
`endif

  assign w_pixel       = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_line_act    = (r_v_cnt < V_ACT);
  assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign w_last_pix    = (r_h_cnt == H_PIX_LAST) && (r_v_cnt == V_PIX_LAST);

  // Next-state and handshake decode from state and raster position
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_state_nxt   = r_state;
    w_ready       = 1'b0;
    w_run         = 1'b0;
    w_sop_take    = 1'b0;
    w_stream_pix  = 1'b0;
    w_frame_begin = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_go) w_state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        // Between frames: drop stray beats, hold a pending SOP.
        w_ready = din_valid & ~din_startofpacket;
        if (w_frame_start) begin
          if (!r_go) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_run         = 1'b1;
            w_frame_begin = 1'b1;
            if (din_valid && din_startofpacket && !w_pattern) begin
              w_sop_take   = 1'b1;
              w_stream_pix = 1'b1;
              w_ready      = 1'b1;
              if (!w_last_pix) w_state_nxt = ST_STREAM;
            end
          end
        end else begin
          w_run = 1'b1;
        end
      end
      ST_STREAM: begin
        w_run = 1'b1;
        if (w_pixel && !r_eop_seen) begin
          w_ready      = 1'b1;
          w_stream_pix = 1'b1;
        end
        if (w_last_pix) w_state_nxt = ST_SYNC;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign din_ready   = w_ready;
  assign w_in_stream = w_sop_take | (r_state == ST_STREAM);
  assign w_take      = w_stream_pix & din_valid;

  // Pixel value for the current slot: stream data, fill, or test pattern
  always_comb begin
    w_pix_val = r_fill;
    if (w_in_stream) begin
      if (w_take) w_pix_val = din_data;
    end else begin
`ifdef DETECTOR_EMU_PATTERN_EN
      if (w_pattern) w_pix_val = w_pat_val;
`endif
    end
  end

  assign w_set[0] = w_stream_pix & ~din_valid;
  assign w_set[1] = w_take & din_endofpacket & ~w_last_pix;
  assign w_set[2] = w_take & ~din_endofpacket & w_last_pix;
  assign w_clr    = (av_write && av_address == 3'd1) ? av_writedata[2:0] : 3'b000;

  // Register read multiplexer; unlisted addresses read 0
  always_comb begin
    w_rd_mux = '0;
    case (av_address)
      3'd0: w_rd_mux = {31'd0, r_go};
      3'd1: w_rd_mux = {29'd0, r_status};
      3'd2: w_rd_mux = {18'd0, r_fill};
      3'd3: w_rd_mux = r_frame_cnt;
`ifdef DETECTOR_EMU_PATTERN_EN
      3'd4: w_rd_mux = {31'd0, r_pattern};
`endif
      default: w_rd_mux = '0;
    endcase
  end

  assign w_unused = ^{av_writedata[31:14], 1'b0};

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Raster counters: held at 0 whenever the raster is not running
  always_ff @(posedge clk) begin
    if (!rst_n || !w_run) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  // Tracks whether the current streamed frame has already consumed its EOP
  always_ff @(posedge clk) begin
    if (!rst_n)                       r_eop_seen <= 1'b0;
    else if (r_state != ST_STREAM)    r_eop_seen <= w_take & din_endofpacket;
    else if (w_take & din_endofpacket) r_eop_seen <= 1'b1;
  end

  // Registered detector outputs, one cycle behind the counter slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_psync <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
      r_video <= '0;
    end else begin
      r_psync <= w_run & w_pixel;
      r_hsync <= w_run & w_pixel;
      r_vsync <= w_run & w_line_act;
      r_video <= (w_run & w_pixel) ? w_pix_val : 14'd0;
    end
  end

  // Control/status registers, frame counter and registered read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_go        <= 1'b0;
      r_status    <= '0;
      r_fill      <= '0;
      r_frame_cnt <= '0;
      r_readdata  <= '0;
`ifdef DETECTOR_EMU_PATTERN_EN
      r_pattern   <= 1'b0;
`endif
    end else begin
      if (av_write && av_address == 3'd0) r_go   <= av_writedata[0];
      if (av_write && av_address == 3'd2) r_fill <= av_writedata[13:0];
`ifdef DETECTOR_EMU_PATTERN_EN
      if (av_write && av_address == 3'd4) r_pattern <= av_writedata[0];
`endif
      // Hardware set wins over a simultaneous software clear.
      r_status <= (r_status & ~w_clr) | w_set;
      if (w_frame_begin) r_frame_cnt <= r_frame_cnt + 32'd1;
      if (av_read) r_readdata <= w_rd_mux;
    end
  end

  assign av_readdata = r_readdata;
  assign dd_psync    = r_psync;
  assign dd_hsync    = r_hsync;
  assign dd_vsync    = r_vsync;
  assign dd_video    = r_video;

endmodule

// File: tb/tb_detector_emulator.sv
// Self-checking bench for detector_emulator on a 4x2 raster (H_BLANK=2,
// V_BLANK=1): directed scenarios plus randomized frames, every cycle compared
// against a slot-position reference model of the raster and stream rules.
module tb_detector_emulator;

  localparam int HA = 4;
  localparam int HB = 2;
  localparam int VA = 2;
  localparam int VB = 1;
  localparam int HT = HA + HB;
  localparam int FT = HT * (VA + VB);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_readdata, av_writedata;
  logic        din_startofpacket, din_endofpacket, din_valid, din_ready;
  logic [13:0] din_data;
  logic        dd_psync, dd_hsync, dd_vsync;
  logic [13:0] dd_video;

  detector_emulator #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)) dut (
    .clk(clk), .rst_n(rst_n),
    .av_address(av_address), .av_read(av_read), .av_readdata(av_readdata),
    .av_write(av_write), .av_writedata(av_writedata),
    .din_startofpacket(din_startofpacket), .din_endofpacket(din_endofpacket),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dd_psync(dd_psync), .dd_hsync(dd_hsync), .dd_vsync(dd_vsync), .dd_video(dd_video)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] data;
    logic        sop;
    logic        eop;
    int          gap;
  } beat_t;

  beat_t       src_q[$];
  logic [13:0] cap_q[$];
  int          cnt_hs, cnt_vs;
  int          n_pass = 0;
  int          n_total = 0;

  // Reference model: raster position as a flat slot index within the frame.
  bit          m_on;
  int          m_pos;
  bit          m_strm;
  bit          m_eop;
  logic        m_go, m_pat;
  logic [2:0]  m_st;
  logic [13:0] m_fill;
  logic [31:0] m_frames;
  logic [16:0] e_dd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_on = 0; m_pos = 0; m_strm = 0; m_eop = 0;
    m_go = 0; m_pat = 0; m_st = '0; m_fill = '0; m_frames = '0; e_dd = '0;
  endtask

  // One clock: drive source, predict, check din_ready, clock, check outputs.
  task automatic cycle();
    beat_t       b;
    int          h, v, n_pos;
    bit          pix, last, strm, eseen, n_on, fbeg, rd_issued;
    logic        rdy;
    logic [13:0] val;
    logic [2:0]  set, clr;
    logic [16:0] n_dd;
    logic [31:0] rd_exp;
    // NOTE: bench inputs are driven with blocking assignments half a cycle before the active edge.
    if (src_q.size() > 0 && src_q[0].gap == 0) begin
      b = src_q[0];
      din_valid = 1'b1; din_data = b.data;
      din_startofpacket = b.sop; din_endofpacket = b.eop;
    end else begin
      din_valid = 1'b0; din_data = 14'($urandom);
      din_startofpacket = 1'($urandom); din_endofpacket = 1'($urandom);
    end
    #1;
    h = m_pos % HT; v = m_pos / HT;
    pix  = (h < HA) && (v < VA);
    last = (h == HA - 1) && (v == VA - 1);
    rdy = 1'b0; set = '0; n_dd = '0; fbeg = 0;
    n_on = m_on; n_pos = m_pos; strm = m_strm; eseen = m_eop;
    if (!m_on) begin
      if (m_go) n_on = 1;
    end else if (m_pos == 0 && !m_go) begin
      n_on = 0;
      rdy = din_valid & ~din_startofpacket;
    end else begin
      if (m_pos == 0) begin
        fbeg  = 1;
        strm  = din_valid && din_startofpacket && !m_pat;
        eseen = 0;
      end
      val = (m_pat && !strm) ? 14'(h + v) : m_fill;
      if (strm && pix && !eseen) begin
        rdy = 1'b1;
        if (din_valid) begin
          val = din_data;
          if (din_endofpacket) begin
            eseen = 1;
            if (!last) set[1] = 1'b1;
          end else if (last) begin
            set[2] = 1'b1;
          end
        end else begin
          set[0] = 1'b1;
        end
      end else if (!strm) begin
        rdy = din_valid & ~din_startofpacket;
      end
      n_pos = (m_pos + 1) % FT;
      n_dd  = {1'(v < VA), 1'(pix), 1'(pix), pix ? val : 14'd0};
      strm  = strm && !last;
    end
    case (av_address)
      3'd0:    rd_exp = {31'd0, m_go};
      3'd1:    rd_exp = {29'd0, m_st};
      3'd2:    rd_exp = {18'd0, m_fill};
      3'd3:    rd_exp = m_frames;
      3'd4:    rd_exp = {31'd0, m_pat};
      default: rd_exp = '0;
    endcase
    check("din_ready", din_ready, rdy);
    rd_issued = av_read;
    clr = (av_write && av_address == 3'd1) ? av_writedata[2:0] : 3'b000;
    @(posedge clk);
    if (din_valid && rdy) void'(src_q.pop_front());
    else if (!din_valid && src_q.size() > 0) begin
      b = src_q[0];
      if (b.gap > 0) begin b.gap--; src_q[0] = b; end
    end
    if (!rst_n) begin
      model_clear();
      rd_exp = '0;
    end else begin
      m_on = n_on; m_pos = n_pos; m_strm = strm; m_eop = eseen; e_dd = n_dd;
      m_st = (m_st & ~clr) | set;
      if (fbeg) m_frames = m_frames + 32'd1;
      if (av_write) begin
        if (av_address == 3'd0) m_go = av_writedata[0];
        if (av_address == 3'd2) m_fill = av_writedata[13:0];
`ifdef DETECTOR_EMU_PATTERN_EN
        if (av_address == 3'd4) m_pat = av_writedata[0];
`endif
      end
    end
    @(negedge clk);
    check("dd_outputs", {dd_vsync, dd_hsync, dd_psync, dd_video}, e_dd);
    if (rd_issued) check("av_readdata", av_readdata, rd_exp);
    if (dd_psync) cap_q.push_back(dd_video);
    cnt_hs += int'(dd_hsync);
    cnt_vs += int'(dd_vsync);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic reg_wr(input logic [2:0] addr, input logic [31:0] data);
    av_address = addr; av_writedata = data; av_write = 1'b1;
    cycle();
    av_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] addr);
    av_address = addr; av_read = 1'b1;
    cycle();
    av_read = 1'b0;
  endtask

  task automatic push_frame(input int n, input int eop_at, input int gap_at, input int base);
    beat_t b;
    for (int i = 1; i <= n; i++) begin
      b.data = 14'(base + i - 1);
      b.sop  = (i == 1);
      b.eop  = (i == eop_at);
      b.gap  = (i == gap_at) ? 1 : 0;
      src_q.push_back(b);
    end
  endtask

  // Advance until the model reaches slot p (optionally inside a streamed frame).
  task automatic wait_slot(input int p, input bit need_strm);
    bit hit = 0;
    for (int i = 0; i < 4 * FT && !hit; i++) begin
      if (m_on && m_pos == p && (m_strm || !need_strm)) hit = 1;
      else cycle();
    end
    check("wait_slot_reached", 32'(hit), 32'd1);
  endtask

  task automatic status_round();
    reg_rd(3'd1);
    reg_rd(3'd3);
    reg_wr(3'd1, 32'h7);
  endtask

  initial begin
    beat_t b;
    int    n, e;
    rst_n = 1'b0; av_address = '0; av_read = 0; av_write = 0; av_writedata = '0;
    din_valid = 0; din_data = '0; din_startofpacket = 0; din_endofpacket = 0;
    cnt_hs = 0; cnt_vs = 0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_dd", {dd_vsync, dd_hsync, dd_psync, dd_video}, 32'd0);
    check("reset_ready", din_ready, 32'd0);
    check("reset_readdata", av_readdata, 32'd0);
    rst_n = 1'b1;

    // Default 4x2 frame: beats 1..8 with SOP/EOP.
    reg_wr(3'd2, 32'h155);
    push_frame(8, 8, 0, 1);
    reg_wr(3'd0, 32'h1);
    cap_q.delete(); cnt_hs = 0; cnt_vs = 0;
    run(FT + 1);
    check("frameA_pixel_count", 32'(cap_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < cap_q.size()) check("frameA_pixel", 32'(cap_q[i]), 32'(i + 1));
    check("frameA_hsync_cycles", 32'(cnt_hs), 32'd8);
    check("frameA_vsync_cycles", 32'(cnt_vs), 32'd12);
    status_round();

    // Underflow on pixel 3.
    push_frame(8, 8, 3, 1);
    run(2 * FT);
    status_round();
    // Short frame: EOP on beat 5.
    push_frame(5, 5, 0, 20);
    run(2 * FT);
    status_round();
    // Long frame: 10 beats.
    push_frame(10, 10, 0, 40);
    run(2 * FT);
    status_round();
    // Fill frame, then an SOP arriving mid-frame.
    wait_slot(8, 0);
    push_frame(8, 8, 0, 100);
    run(2 * FT);
    status_round();

    // Randomized frames with stray beats, gaps and random lengths.
    for (int k = 0; k < 8; k++) begin
      for (int s = 0; s < int'($urandom_range(0, 2)); s++) begin
        b.data = 14'($urandom); b.sop = 0; b.eop = 1'($urandom); b.gap = 0;
        src_q.push_back(b);
      end
      n = $urandom_range(1, 11);
      e = ($urandom_range(0, 3) == 0) ? 0 : n;
      for (int i = 1; i <= n; i++) begin
        b.data = 14'($urandom); b.sop = (i == 1); b.eop = (i == e);
        b.gap  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0;
        src_q.push_back(b);
      end
      run(2 * FT);
      status_round();
    end
    src_q.delete();

    // go cleared mid-frame: frame completes, then idle.
    push_frame(8, 8, 0, 200);
    wait_slot(4, 1);
    reg_wr(3'd0, 32'h0);
    run(2 * FT);
    check("idle_after_go_clear", {dd_vsync, dd_hsync, dd_psync, dd_video}, 32'd0);
    check("idle_ready", din_ready, 32'd0);
    status_round();

    // Register 4 without the pattern feature reads 0.
    reg_wr(3'd4, 32'h1);
    reg_rd(3'd4);

    // Reset mid-frame.
    reg_wr(3'd0, 32'h1);
    push_frame(8, 8, 0, 300);
    wait_slot(7, 1);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check("reset_mid_dd", {dd_vsync, dd_hsync, dd_psync, dd_video}, 32'd0);
    for (int a = 0; a < 5; a++) reg_rd(3'(a));
    src_q.delete();

`ifdef DETECTOR_EMU_PATTERN_EN
    // Pattern frames: non-SOP beats drained, SOP held.
    reg_wr(3'd4, 32'h1);
    reg_wr(3'd0, 32'h1);
    push_frame(3, 0, 0, 7);
    b.data = 14'd9; b.sop = 0; b.eop = 0; b.gap = 0;
    src_q.push_front(b);
    run(2 * FT);
    reg_rd(3'd4);
    status_round();
    src_q.delete();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
